// File: rtl/pc_next_ctrl.sv
// pc_next_ctrl: next-PC generator and PC load strobe for the program counter.
// It walks a FETCH -> EXEC cycle and resolves SEQ, JMP, BRZ, CALL, RET and
// HALT ops. CALL and RET use a small circular return-address stack. All
// outputs come straight from flops.
module pc_next_ctrl #(
  parameter int RAS_DEPTH = 4,
  parameter int AW        = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc_cur,
  input  logic          imem_rdy,
  input  logic          op_valid,
  input  logic [2:0]    op_type,
  input  logic [AW-1:0] target,
  input  logic          zero_flag,
  input  logic          stall,
  input  logic          resume,
  output logic [AW-1:0] mux1op,
  output logic          PCCR,
  output logic          halted,
  output logic          ras_ovf,
  output logic          ras_unf
);

  // The stack pointer wraps for free because RAS_DEPTH is a power of two.
  // The count needs one extra bit so that it can hold RAS_DEPTH itself.
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BRZ  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] mux1op_q, mux1op_d;
  logic          pccr_q, pccr_d;
  logic          halted_q, halted_d;
  logic          ras_ovf_q, ras_ovf_d;
  logic          ras_unf_q, ras_unf_d;
  logic [PW-1:0] ras_ptr_q, ras_ptr_d;
  logic [CW-1:0] ras_cnt_q, ras_cnt_d;
  logic [AW-1:0] ras_q [RAS_DEPTH];
  logic [AW-1:0] ras_d [RAS_DEPTH];

  logic [AW-1:0] pc_plus1;
  logic [PW-1:0] ras_top_idx;

  // ras_ptr_q points at the next free slot, so the top entry sits just below it.
  assign pc_plus1    = pc_cur + AW'(1);
  assign ras_top_idx = ras_ptr_q - PW'(1);

  // Next-state logic. PCCR defaults low, so a strobe can only last one cycle.
  always_comb begin
    state_d   = state_q;
    mux1op_d  = mux1op_q;
    pccr_d    = 1'b0;
    halted_d  = halted_q;
    ras_ovf_d = ras_ovf_q;
    ras_unf_d = ras_unf_q;
    ras_ptr_d = ras_ptr_q;
    ras_cnt_d = ras_cnt_q;
    ras_d     = ras_q;

    case (state_q)
      ST_FETCH: begin
        halted_d = 1'b0;
        if (imem_rdy) begin
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (!stall && op_valid) begin
          state_d = ST_FETCH;
          pccr_d  = 1'b1;
          case (op_type)
            OP_JMP: begin
              mux1op_d = target;
            end
            OP_BRZ: begin
              mux1op_d = zero_flag ? target : pc_plus1;
            end
            OP_CALL: begin
              // When the stack is full, the push overwrites the oldest entry.
              mux1op_d         = target;
              ras_d[ras_ptr_q] = pc_plus1;
              ras_ptr_d        = ras_ptr_q + PW'(1);
              if (ras_cnt_q == RAS_FULL) begin
                ras_ovf_d = 1'b1;
              end else begin
                ras_cnt_d = ras_cnt_q + CW'(1);
              end
            end
            OP_RET: begin
              if (ras_cnt_q == '0) begin
                mux1op_d  = pc_plus1;
                ras_unf_d = 1'b1;
              end else begin
                mux1op_d  = ras_q[ras_top_idx];
                ras_ptr_d = ras_top_idx;
                ras_cnt_d = ras_cnt_q - CW'(1);
              end
            end
            OP_HALT: begin
              pccr_d   = 1'b0;
              halted_d = 1'b1;
              state_d  = ST_HALTED;
            end
            default: begin
              mux1op_d = pc_plus1;
            end
          endcase
        end
      end

      ST_HALTED: begin
        halted_d = 1'b1;
        if (resume) begin
          halted_d = 1'b0;
          state_d  = ST_FETCH;
        end
      end

      default: begin
        state_d  = ST_FETCH;
        halted_d = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset takes priority over every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      mux1op_q  <= '0;
      pccr_q    <= 1'b0;
      halted_q  <= 1'b0;
      ras_ovf_q <= 1'b0;
      ras_unf_q <= 1'b0;
      ras_ptr_q <= '0;
      ras_cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      mux1op_q  <= mux1op_d;
      pccr_q    <= pccr_d;
      halted_q  <= halted_d;
      ras_ovf_q <= ras_ovf_d;
      ras_unf_q <= ras_unf_d;
      ras_ptr_q <= ras_ptr_d;
      ras_cnt_q <= ras_cnt_d;
      for (int i = 0; i < RAS_DEPTH; i++) begin
        ras_q[i] <= ras_d[i];
      end
    end
  end

  assign mux1op  = mux1op_q;
  assign PCCR    = pccr_q;
  assign halted  = halted_q;
  assign ras_ovf = ras_ovf_q;
  assign ras_unf = ras_unf_q;

endmodule

// File: tb/tb_pc_next_ctrl.sv
// tb_pc_next_ctrl: directed checks of pc_next_ctrl (RAS_DEPTH=4, AW=8).
module tb_pc_next_ctrl;

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BRZ  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;
  localparam logic [2:0] OP_HALT = 3'd5;

  logic       clk;
  logic       rst;
  logic [7:0] pc_cur;
  logic       imem_rdy;
  logic       op_valid;
  logic [2:0] op_type;
  logic [7:0] target;
  logic       zero_flag;
  logic       stall;
  logic       resume;
  logic [7:0] mux1op;
  logic       PCCR;
  logic       halted;
  logic       ras_ovf;
  logic       ras_unf;

  int checks;
  int failures;

  pc_next_ctrl #(.RAS_DEPTH(4), .AW(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .pc_cur   (pc_cur),
    .imem_rdy (imem_rdy),
    .op_valid (op_valid),
    .op_type  (op_type),
    .target   (target),
    .zero_flag(zero_flag),
    .stall    (stall),
    .resume   (resume),
    .mux1op   (mux1op),
    .PCCR     (PCCR),
    .halted   (halted),
    .ras_ovf  (ras_ovf),
    .ras_unf  (ras_unf)
  );

  // 10-time-unit system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge so registered outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Walk one op through FETCH and EXEC. On return, the accept edge has just passed.
  task automatic do_op(input logic [2:0] op, input logic [7:0] tgt,
                       input logic [7:0] pc, input logic zf);
    pc_cur    = pc;
    op_type   = op;
    target    = tgt;
    zero_flag = zf;
    stall     = 1'b0;
    imem_rdy  = 1'b1;
    op_valid  = 1'b1;
    tick();
    tick();
    imem_rdy  = 1'b0;
    op_valid  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (mux1op !== 8'h00) begin failures++; $display("[TB] FAIL reset_mux1op got=%h exp=00", mux1op); end
    checks++; if (PCCR !== 1'b0) begin failures++; $display("[TB] FAIL reset_pccr got=%b exp=0", PCCR); end
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (ras_ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b exp=0", ras_ovf); end
    checks++; if (ras_unf !== 1'b0) begin failures++; $display("[TB] FAIL reset_unf got=%b exp=0", ras_unf); end
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    pc_cur   = 8'h10;
    op_type  = OP_SEQ;
    imem_rdy = 1'b1;
    op_valid = 1'b1;
    tick();
    checks++; if (PCCR !== 1'b0) begin failures++; $display("[TB] FAIL seq_early_pccr got=%b exp=0", PCCR); end
    tick();
    checks++; if (PCCR !== 1'b1) begin failures++; $display("[TB] FAIL seq_pccr got=%b exp=1", PCCR); end
    checks++; if (mux1op !== 8'h11) begin failures++; $display("[TB] FAIL seq_mux1op got=%h exp=11", mux1op); end
    imem_rdy = 1'b0;
    op_valid = 1'b0;
    tick();
    checks++; if (PCCR !== 1'b0) begin failures++; $display("[TB] FAIL seq_pulse_width got=%b exp=0", PCCR); end
    tick();
    checks++; if (PCCR !== 1'b0) begin failures++; $display("[TB] FAIL seq_idle_pccr got=%b exp=0", PCCR); end
  endtask

  task automatic test_wrap();
    do_op(OP_SEQ, 8'h00, 8'hFF, 1'b0);
    checks++; if (mux1op !== 8'h00) begin failures++; $display("[TB] FAIL wrap_seq got=%h exp=00", mux1op); end
    do_op(OP_BRZ, 8'h40, 8'hFF, 1'b1);
    checks++; if (mux1op !== 8'h40) begin failures++; $display("[TB] FAIL brz_taken got=%h exp=40", mux1op); end
    do_op(OP_BRZ, 8'h40, 8'hFF, 1'b0);
    checks++; if (mux1op !== 8'h00) begin failures++; $display("[TB] FAIL brz_not_taken got=%h exp=00", mux1op); end
    do_op(3'd7, 8'h40, 8'h33, 1'b1);
    checks++; if (mux1op !== 8'h34) begin failures++; $display("[TB] FAIL op7_as_seq got=%h exp=34", mux1op); end
  endtask

  task automatic test_call_return();
    do_op(OP_CALL, 8'h20, 8'h05, 1'b0);
    checks++; if (mux1op !== 8'h20) begin failures++; $display("[TB] FAIL call1 got=%h exp=20", mux1op); end
    do_op(OP_CALL, 8'h30, 8'h22, 1'b0);
    checks++; if (mux1op !== 8'h30) begin failures++; $display("[TB] FAIL call2 got=%h exp=30", mux1op); end
    do_op(OP_RET, 8'h99, 8'h31, 1'b0);
    checks++; if (mux1op !== 8'h23) begin failures++; $display("[TB] FAIL ret1 got=%h exp=23", mux1op); end
    do_op(OP_RET, 8'h99, 8'h24, 1'b0);
    checks++; if (mux1op !== 8'h06) begin failures++; $display("[TB] FAIL ret2 got=%h exp=06", mux1op); end
    checks++; if (ras_unf !== 1'b0) begin failures++; $display("[TB] FAIL unf_before got=%b exp=0", ras_unf); end
    do_op(OP_RET, 8'h99, 8'h50, 1'b0);
    checks++; if (mux1op !== 8'h51) begin failures++; $display("[TB] FAIL ret_empty got=%h exp=51", mux1op); end
    checks++; if (ras_unf !== 1'b1) begin failures++; $display("[TB] FAIL unf_set got=%b exp=1", ras_unf); end
    do_op(OP_JMP, 8'h12, 8'h51, 1'b0);
    checks++; if (ras_unf !== 1'b1) begin failures++; $display("[TB] FAIL unf_sticky got=%b exp=1", ras_unf); end
    checks++; if (ras_ovf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_quiet got=%b exp=0", ras_ovf); end
  endtask

  task automatic test_ras_overflow();
    logic [7:0] exp_ret [4];
    exp_ret = '{8'h06, 8'h05, 8'h04, 8'h03};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (ras_unf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_pre_unf got=%b exp=0", ras_unf); end
    for (int i = 0; i < 5; i++) begin
      do_op(OP_CALL, 8'h70, 8'(i + 1), 1'b0);
      if (i == 3) begin
        checks++; if (ras_ovf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_at_full got=%b exp=0", ras_ovf); end
      end
    end
    checks++; if (ras_ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_set got=%b exp=1", ras_ovf); end
    for (int i = 0; i < 4; i++) begin
      do_op(OP_RET, 8'h99, 8'h70, 1'b0);
      checks++; if (mux1op !== exp_ret[i]) begin failures++; $display("[TB] FAIL ovf_ret%0d got=%h exp=%h", i, mux1op, exp_ret[i]); end
    end
    checks++; if (ras_unf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_unf_early got=%b exp=0", ras_unf); end
    do_op(OP_RET, 8'h99, 8'h70, 1'b0);
    checks++; if (mux1op !== 8'h71) begin failures++; $display("[TB] FAIL ovf_ret_empty got=%h exp=71", mux1op); end
    checks++; if (ras_unf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_unf got=%b exp=1", ras_unf); end
    checks++; if (ras_ovf !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky got=%b exp=1", ras_ovf); end
  endtask

  task automatic test_stall();
    pc_cur   = 8'h60;
    op_type  = OP_JMP;
    target   = 8'h80;
    imem_rdy = 1'b1;
    op_valid = 1'b1;
    stall    = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (PCCR !== 1'b0) begin failures++; $display("[TB] FAIL stall_pccr%0d got=%b exp=0", i, PCCR); end
    end
    stall = 1'b0;
    tick();
    checks++; if (PCCR !== 1'b1) begin failures++; $display("[TB] FAIL stall_release_pccr got=%b exp=1", PCCR); end
    checks++; if (mux1op !== 8'h80) begin failures++; $display("[TB] FAIL stall_release_mux got=%h exp=80", mux1op); end
    imem_rdy = 1'b0;
    op_valid = 1'b0;
    tick();
    checks++; if (PCCR !== 1'b0) begin failures++; $display("[TB] FAIL stall_single_pulse got=%b exp=0", PCCR); end
  endtask

  task automatic test_halt();
    do_op(OP_HALT, 8'h11, 8'h80, 1'b0);
    checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL halt_flag got=%b exp=1", halted); end
    checks++; if (PCCR !== 1'b0) begin failures++; $display("[TB] FAIL halt_pccr got=%b exp=0", PCCR); end
    checks++; if (mux1op !== 8'h80) begin failures++; $display("[TB] FAIL halt_mux got=%h exp=80", mux1op); end
    op_type  = OP_JMP;
    target   = 8'h11;
    op_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      imem_rdy = ~imem_rdy;
      tick();
      checks++; if (PCCR !== 1'b0 || halted !== 1'b1) begin failures++; $display("[TB] FAIL halt_hold%0d got pccr=%b halted=%b exp pccr=0 halted=1", i, PCCR, halted); end
    end
    imem_rdy = 1'b0;
    op_valid = 1'b0;
    resume   = 1'b1;
    tick();
    resume   = 1'b0;
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL resume_halted got=%b exp=0", halted); end
    checks++; if (mux1op !== 8'h80) begin failures++; $display("[TB] FAIL resume_mux got=%h exp=80", mux1op); end
    do_op(OP_SEQ, 8'h00, 8'h80, 1'b0);
    checks++; if (PCCR !== 1'b1 || mux1op !== 8'h81) begin failures++; $display("[TB] FAIL resume_fetch got pccr=%b mux=%h exp pccr=1 mux=81", PCCR, mux1op); end
  endtask

  task automatic test_reset_mid();
    do_op(OP_CALL, 8'h90, 8'h10, 1'b0);
    pc_cur   = 8'h90;
    op_type  = OP_JMP;
    target   = 8'h80;
    imem_rdy = 1'b1;
    op_valid = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (PCCR !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_pccr got=%b exp=0", PCCR); end
    checks++; if (mux1op !== 8'h00) begin failures++; $display("[TB] FAIL rstmid_mux got=%h exp=00", mux1op); end
    checks++; if (ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_flags got ovf=%b unf=%b exp 0 0", ras_ovf, ras_unf); end
    tick();
    checks++; if (PCCR !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_state_fetch got=%b exp=0", PCCR); end
    tick();
    checks++; if (PCCR !== 1'b1 || mux1op !== 8'h80) begin failures++; $display("[TB] FAIL rstmid_jmp got pccr=%b mux=%h exp pccr=1 mux=80", PCCR, mux1op); end
    imem_rdy = 1'b0;
    op_valid = 1'b0;
    tick();
    do_op(OP_RET, 8'h99, 8'h40, 1'b0);
    checks++; if (mux1op !== 8'h41 || ras_unf !== 1'b1) begin failures++; $display("[TB] FAIL rstmid_ras_empty got mux=%h unf=%b exp mux=41 unf=1", mux1op, ras_unf); end
  endtask

  // Run every scenario in order, then print the summary line.
  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    pc_cur    = 8'h00;
    imem_rdy  = 1'b0;
    op_valid  = 1'b0;
    op_type   = OP_SEQ;
    target    = 8'h00;
    zero_flag = 1'b0;
    stall     = 1'b0;
    resume    = 1'b0;
    test_reset();
    test_sequential();
    test_wrap();
    test_call_return();
    test_ras_overflow();
    test_stall();
    test_halt();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_next_ctrl.md
Name: pc_next_ctrl

Overview:
- Control end of the program-counter interface: generates the next PC value and the one-cycle PC load strobe that the program counter register samples.
- Sequences fetch and execute, and resolves sequential, jump, branch-on-zero, call, return and halt.
- Holds a small circular return-address stack (RAS).
- Sits between the decode stage and the program counter; reads back the current PC.

Parameters:
- RAS_DEPTH, 4, number of return-address stack entries (power of 2, at least 2).
- AW, 8, PC/address width.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- pc_cur  input  AW  current PC value read back from the program counter.
- imem_rdy  input  1  instruction memory has valid instruction for pc_cur.
- op_valid  input  1  decode presents a resolved control op.
- op_type  input  3  0 SEQ, 1 JMP, 2 BRZ, 3 CALL, 4 RET, 5 HALT, 6-7 treated as SEQ.
- target  input  AW  absolute target for JMP, BRZ and CALL.
- zero_flag  input  1  ALU zero flag, used by BRZ.
- stall  input  1  hold; blocks the EXEC decision.
- resume  input  1  leave HALTED.
- mux1op  output  AW  next-PC value to load (registered).
- PCCR  output  1  PC load strobe, one-cycle pulse (registered).
- halted  output  1  high while in HALTED.
- ras_ovf  output  1  sticky: CALL pushed with stack full.
- ras_unf  output  1  sticky: RET popped with stack empty.

Behaviour:
- Reset:
  - rst=1 at a posedge forces state=FETCH, mux1op=0, PCCR=0, halted=0, ras_ovf=0, ras_unf=0.
  - RAS pointer and count are cleared to 0.
  - rst has priority over every other input and in every state, including mid-EXEC and HALTED.
- All outputs are registered; there is no combinational input-to-output path.
- FETCH:
  - PCCR=0.
  - imem_rdy=1 moves to EXEC next cycle; otherwise stay.
- EXEC:
  - stall=1: hold state; no RAS change, no strobe. stall wins over op_valid.
  - op_valid=0: hold.
  - op_valid=1 and stall=0: compute next PC, register it into mux1op, set PCCR=1 for exactly that one cycle, then go to FETCH (op_type 5 goes to HALTED instead).
  - The program counter loads mux1op at the edge following PCCR=1; total latency from accepted op to PC update is 2 edges.
- Next-PC rules; all arithmetic is modulo 2^AW, so 0xFF+1 wraps to 0x00:
  - SEQ: pc_cur+1.
  - JMP: target.
  - BRZ: target if zero_flag=1, else pc_cur+1.
  - CALL: target; push pc_cur+1.
  - RET: pop the top entry. If the stack is empty, use pc_cur+1 and set ras_unf.
  - HALT: no strobe, PCCR stays 0, mux1op unchanged, halted=1.
- RAS push with count=RAS_DEPTH:
  - Overwrite the oldest entry (circular).
  - Count stays RAS_DEPTH.
  - Set ras_ovf.
- RAS pop: returns the most recent push (LIFO) and decrements count.
- HALTED:
  - halted=1, PCCR=0, all inputs except rst and resume ignored.
  - resume=1 moves to FETCH next cycle with halted=0, PC unchanged.
- Invariants:
  - Never two consecutive PCCR=1 cycles.
  - PCCR=1 only in the cycle after an accepted EXEC.
- ras_ovf and ras_unf are cleared only by rst.

Test Plan:
- Reset then sequential run: rst 1 cycle; pc_cur=0x10, imem_rdy=1, op SEQ → mux1op=0x11 with a single PCCR pulse 2 cycles after imem_rdy; PCCR=0 elsewhere.
- Wrap-around: pc_cur=0xFF, SEQ → mux1op=0x00. BRZ target 0x40 with zero_flag=0 at pc_cur=0xFF → 0x00; with zero_flag=1 → 0x40.
- Call/return nesting:
  - CALL target 0x20 from pc 0x05, then CALL 0x30 from pc 0x22.
  - RET → 0x23, then RET → 0x06.
  - Next RET with empty stack at pc 0x50 → 0x51 and ras_unf=1, staying high.
- RAS overflow:
  - 5 CALLs from pcs 0x01,0x02,0x03,0x04,0x05 with RAS_DEPTH=4 → ras_ovf=1.
  - 4 RETs yield 0x06,0x05,0x04,0x03.
  - 5th RET sets ras_unf.
- Stall and halt:
  - stall=1 with op_valid=1 JMP 0x80 for 3 cycles → no PCCR. Release → PCCR once, mux1op=0x80.
  - HALT → halted=1, no strobe; imem_rdy toggling is ignored.
  - resume → FETCH, halted=0.
- Reset mid-operation: assert rst in EXEC with op_valid=1 JMP 0x80 → no PCCR, mux1op=0, RAS empty, flags cleared, state FETCH.
